// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states and
// small decode helpers. Opcode 11 (MUL) is only live when ALU_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAnd  = 4'd0,
    OpOr   = 4'd1,
    OpNotA = 4'd2,
    OpNor  = 4'd3,
    OpXor  = 4'd4,
    OpNand = 4'd5,
    OpAdd  = 4'd6,
    OpSub  = 4'd7,
    OpSll  = 4'd8,
    OpSrl  = 4'd9,
    OpSra  = 4'd10,
    OpMul  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the operand stage, the ALU and writeback.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       sel;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             Cout;
  logic             Negative;
  logic             Zero;
  logic             Overflow;

  modport master (
    output in_valid, A, B, sel, Cin, out_ready,
    input  in_ready, out_valid, Y, Cout, Negative, Zero, Overflow
  );

  modport slave (
    input  in_valid, A, B, sel, Cin, out_ready,
    output in_ready, out_valid, Y, Cout, Negative, Zero, Overflow
  );
endinterface

// File: rtl/alu_comb_unit.sv
// Single-cycle datapath: logic ops, ADD/SUB and their flags. Shift opcodes
// pass A through (the zero-distance shift result); MUL and unused opcodes
// yield Y=0 so the caller sees the illegal-op result.
module alu_comb_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o,
  output logic             negative_o,
  output logic             zero_o,
  output logic             overflow_o
);
  logic             arith;
  logic             c_in;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Result mux plus flag generation; SUB reuses the adder as A + ~B + 1.
  always_comb begin
    arith = (op_i == OpAdd) || (op_i == OpSub);
    b_eff = (op_i == OpSub) ? ~b_i : b_i;
    c_in  = (op_i == OpSub) ? 1'b1 : cin_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};
    y_o   = '0;
    case (op_i)
      OpAnd:               y_o = a_i & b_i;
      OpOr:                y_o = a_i | b_i;
      OpNotA:              y_o = ~a_i;
      OpNor:               y_o = ~(a_i | b_i);
      OpXor:               y_o = a_i ^ b_i;
      OpNand:              y_o = ~(a_i & b_i);
      OpAdd, OpSub:        y_o = sum[WIDTH-1:0];
      OpSll, OpSrl, OpSra: y_o = a_i;
      default:             y_o = '0;
    endcase
    // For SUB the adder carry is the no-borrow flag.
    cout_o     = arith & sum[WIDTH];
    overflow_o = arith & (a_i[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
    negative_o = y_o[WIDTH-1];
    zero_o     = (y_o == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: handshake FSM, iterative shifter and (with ALU_MUL_EN
// defined) a shift-add multiplier. Results and flags are registered and held
// in DONE until out_ready. Without ALU_MUL_EN opcode 11 is treated as illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q, neg_q, zero_q, ovf_q;

  logic             accept, go_busy, last;
  logic             is_mul_in, is_mul_q;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shift_nxt, busy_y;
  logic             shift_out, busy_cout, busy_ovf;
  logic [WIDTH-1:0] cu_y;
  logic             cu_cout, cu_neg, cu_zero, cu_ovf;

  assign shamt   = bus.B[SHW-1:0];
  assign accept  = bus.in_valid && (state_q == StIdle);
  assign go_busy = is_mul_in || (is_shift(bus.sel) && (shamt != '0));
  assign last    = (cnt_q == CW'(1));

  alu_comb_unit #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a_i       (bus.A),
    .b_i       (bus.B),
    .op_i      (bus.sel),
    .cin_i     (bus.Cin),
    .y_o       (cu_y),
    .cout_o    (cu_cout),
    .negative_o(cu_neg),
    .zero_o    (cu_zero),
    .overflow_o(cu_ovf)
  );

  // One-bit shift step; shift_out is the bit leaving the word this cycle.
  always_comb begin
    shift_nxt = work_q;
    shift_out = 1'b0;
    case (op_q)
      OpSll: begin
        shift_nxt = {work_q[WIDTH-2:0], 1'b0};
        shift_out = work_q[WIDTH-1];
      end
      OpSrl: begin
        shift_nxt = {1'b0, work_q[WIDTH-1:1]};
        shift_out = work_q[0];
      end
      OpSra: begin
        shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        shift_out = work_q[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_nxt;
  logic [WIDTH:0]     hi_sum;

  assign is_mul_in = (bus.sel == OpMul);
  assign is_mul_q  = (op_q == OpMul);

  // Right-shifting accumulator: low half starts as the multiplier, its LSB
  // selects whether the multiplicand is added into the high half.
  always_comb begin
    hi_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, work_q} : '0);
    acc_nxt = {hi_sum, acc_q[WIDTH-1:1]};
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= {{WIDTH{1'b0}}, bus.B};
    end else if ((state_q == StBusy) && is_mul_q) begin
      acc_q <= acc_nxt;
    end
  end
`else
  assign is_mul_in = 1'b0;
  assign is_mul_q  = 1'b0;
`endif

  // Final-iteration result of whichever multi-cycle op is running.
  always_comb begin
    busy_y    = shift_nxt;
    busy_cout = shift_out;
    busy_ovf  = 1'b0;
`ifdef ALU_MUL_EN
    if (is_mul_q) begin
      busy_y    = acc_nxt[WIDTH-1:0];
      busy_cout = 1'b0;
      busy_ovf  = |acc_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = go_busy ? StBusy : StDone;
      StBusy:  if (last) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
  end

  // Operand latch, iteration and result/flag registers; held untouched in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      cout_q <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= bus.sel;
            work_q <= bus.A;
            cnt_q  <= is_mul_in ? CW'(WIDTH) : CW'(shamt);
            if (!go_busy) begin
              y_q    <= cu_y;
              cout_q <= cu_cout;
              neg_q  <= cu_neg;
              zero_q <= cu_zero;
              ovf_q  <= cu_ovf;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CW'(1);
          if (!is_mul_q) work_q <= shift_nxt;
          if (last) begin
            y_q    <= busy_y;
            cout_q <= busy_cout;
            neg_q  <= busy_y[WIDTH-1];
            zero_q <= (busy_y == '0);
            ovf_q  <= busy_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Y        = y_q;
  assign bus.Cout     = cout_q;
  assign bus.Negative = neg_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32). Build with +define+ALU_MUL_EN to
// cover the multiplier; otherwise opcode 11 is expected to behave as illegal.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] y;
    logic [3:0]   flags;  // {Cout, Negative, Zero, Overflow}
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc++;

  function automatic void check(input string nm, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.Cout, bus.Negative, bus.Zero, bus.Overflow};
  endfunction

  // Monitor: measures latency to out_valid, watches hold stability and
  // compares against the scoreboard when the result is consumed.
  logic         seen   = 1'b0;
  logic         stable = 1'b1;
  int           rise   = 0;
  logic [W+3:0] snap;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen   = 1'b1;
        rise   = cyc;
        stable = 1'b1;
        snap   = {bus.Y, dut_flags()};
      end else if ({bus.Y, dut_flags()} !== snap) begin
        stable = 1'b0;
      end
      if (bus.out_ready) begin
        seen = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got Y=0x%0h, expected no result", bus.Y);
        end else begin
          e = sb.pop_front();
          check({e.name, " Y"}, bus.Y, e.y);
          check({e.name, " flags"}, W'(dut_flags()), W'(e.flags));
          check({e.name, " latency"}, W'(rise - e.acc), W'(e.lat));
          check({e.name, " held_stable"}, W'(stable), W'(1));
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c, input logic [W-1:0] ey,
                       input logic [3:0] ef, input int lat);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = c;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL %s accept_timeout: in_ready=0 after %0d cycles, expected 1", nm, waited);
      bus.in_valid = 1'b0;
    end else begin
      e.name  = nm;
      e.y     = ey;
      e.flags = ef;
      e.lat   = lat;
      e.acc   = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic ir_bad;
  logic stale;

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.sel       = '0;
    bus.Cin       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("reset in_ready", W'(bus.in_ready), 1);
    check("reset out_valid", W'(bus.out_valid), 0);
    check("reset Y", bus.Y, 0);
    check("reset flags", W'(dut_flags()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name         sel     A             B             Cin   Y             CNZV     lat
    issue("and",       OpAnd,  32'hF0F000FF, 32'h0FF00F0F, 1'b0, 32'h00F0000F, 4'b0000, 1);
    issue("or",        OpOr,   32'h12340000, 32'h00005678, 1'b0, 32'h12345678, 4'b0000, 1);
    issue("nota",      OpNotA, 32'h0000FFFF, 32'h12345678, 1'b0, 32'hFFFF0000, 4'b0100, 1);
    issue("nor",       OpNor,  32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'h00000000, 4'b0010, 1);
    issue("xor",       OpXor,  32'hAAAA5555, 32'hFFFFFFFF, 1'b0, 32'h5555AAAA, 4'b0000, 1);
    issue("nand",      OpNand, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0010, 1);
    issue("add_ovf",   OpAdd,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0101, 1);
    issue("add_cin",   OpAdd,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b1010, 1);
    issue("add_small", OpAdd,  32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 4'b0000, 1);
    issue("sub_neg",   OpSub,  32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 4'b0100, 1);
    issue("sub_eq",    OpSub,  32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 4'b1010, 1);
    issue("sub_ovf",   OpSub,  32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b1001, 1);
    issue("sra4",      OpSra,  32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 4'b0100, 5);
    issue("sll1",      OpSll,  32'h80000001, 32'h00000001, 1'b0, 32'h00000002, 4'b1000, 2);
    issue("srl1",      OpSrl,  32'h80000003, 32'h00000001, 1'b0, 32'h40000001, 4'b1000, 2);
    issue("srl31",     OpSrl,  32'h80000000, 32'h0000001F, 1'b0, 32'h00000001, 4'b0000, 32);
    issue("sll0",      OpSll,  32'h12345678, 32'h00000020, 1'b0, 32'h12345678, 4'b0000, 1);
    issue("illegal13", 4'd13,  32'h00000005, 32'h00000006, 1'b0, 32'h00000000, 4'b0010, 1);
`ifdef ALU_MUL_EN
    issue("mul_wrap",  OpMul,  32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 4'b0011, 33);
    issue("mul_small", OpMul,  32'h00000003, 32'h00000005, 1'b0, 32'h0000000F, 4'b0000, 33);
    issue("mul_max",   OpMul,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 4'b0001, 33);
`else
    issue("mul_off",   OpMul,  32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 4'b0010, 1);
`endif
    wait_drain(200);

    // Backpressure: result held 10 cycles, stray requests must be ignored.
    bus.out_ready = 1'b0;
    issue("hold_add",  OpAdd,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0101, 1);
    ir_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
      if (i >= 2 && i <= 4) begin
        bus.in_valid = 1'b1;
        bus.sel      = OpAnd;
        bus.A        = 32'h0000FFFF;
        bus.B        = 32'h0000FFFF;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("hold in_ready", W'(ir_bad), 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain(20);
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    check("hold no_extra_result", W'(stale), 0);

    // Abort a multi-cycle op with reset; nothing may surface afterwards.
    @(negedge clk);
    bus.in_valid = 1'b1;
`ifdef ALU_MUL_EN
    bus.sel = OpMul;
    bus.A   = 32'h00000003;
    bus.B   = 32'h00000005;
`else
    bus.sel = OpSll;
    bus.A   = 32'h00000001;
    bus.B   = 32'h0000001F;
`endif
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort busy in_ready", W'(bus.in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", W'(bus.out_valid), 0);
    check("abort in_ready", W'(bus.in_ready), 1);
    check("abort Y", bus.Y, 0);
    check("abort flags", W'(dut_flags()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    check("abort no_stale_result", W'(stale), 0);

    issue("recover",   OpXor,  32'h0F0F0F0F, 32'hFFFF0000, 1'b0, 32'hF0F00F0F, 4'b0100, 1);
    wait_drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
